// File: rtl/pcie_cpl_tlp_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pcie_cpl_tlp_gen
// Purpose  : Builds PCIe completion TLPs (header + dword-packed data) from a
//            completion descriptor and AXI read beats, split at max payload.
//            Optional statistics counters are enabled with CPL_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pcie_cpl_tlp_gen #(
    parameter int TLP_DATA_WIDTH = 256,
    parameter int TLP_STRB_WIDTH = TLP_DATA_WIDTH / 32,
    parameter int TLP_HDR_WIDTH  = 128
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [15:0]               completer_id,
    input  logic [2:0]                max_payload_size,
    input  logic                      desc_valid,
    output logic                      desc_ready,
    input  logic [15:0]               desc_requester_id,
    input  logic [7:0]                desc_tag,
    input  logic [2:0]                desc_tc,
    input  logic [2:0]                desc_attr,
    input  logic [6:0]                desc_lower_addr,
    input  logic [10:0]               desc_dw_count,
    input  logic [2:0]                desc_status,
    input  logic [TLP_DATA_WIDTH-1:0] rd_data,
    input  logic                      rd_valid,
    output logic                      rd_ready,
    output logic [TLP_DATA_WIDTH-1:0] tx_cpl_tlp_data,
    output logic [TLP_STRB_WIDTH-1:0] tx_cpl_tlp_strb,
    output logic [TLP_HDR_WIDTH-1:0]  tx_cpl_tlp_hdr,
    output logic                      tx_cpl_tlp_valid,
    output logic                      tx_cpl_tlp_sop,
    output logic                      tx_cpl_tlp_eop,
    input  logic                      tx_cpl_tlp_ready
`ifdef CPL_STATS_EN
    ,
    output logic [31:0]               stat_cpl_count,
    output logic [15:0]               stat_ur_count,
    output logic [15:0]               stat_ca_count
`endif
);

    localparam logic [10:0] c_strb_dw = 11'(TLP_STRB_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_NODATA = 2'd1,
        ST_DATA   = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [15:0]                 req_id_q, req_id_d;
    logic [7:0]                  tag_q, tag_d;
    logic [2:0]                  tc_q, tc_d;
    logic [2:0]                  attr_q, attr_d;
    logic [2:0]                  status_q, status_d;
    logic [6:0]                  lower_addr_q, lower_addr_d;
    logic [10:0]                 rem_dw_q, rem_dw_d;
    logic [10:0]                 mps_dw_q, mps_dw_d;
    logic                        in_tlp_q, in_tlp_d;
    logic [10:0]                 tlp_dw_q, tlp_dw_d;
    logic [10:0]                 tlp_left_q, tlp_left_d;
    logic                        out_valid_q, out_valid_d;
    logic                        out_sop_q, out_sop_d;
    logic                        out_eop_q, out_eop_d;
    logic [TLP_STRB_WIDTH-1:0]   out_strb_q, out_strb_d;
    logic [TLP_DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic [TLP_HDR_WIDTH-1:0]    out_hdr_q, out_hdr_d;

    logic                        w_out_free;
    logic                        w_desc_fire;
    logic                        w_rd_fire;
    logic                        w_is_data;
    logic [10:0]                 w_new_tlp_dw;
    logic [10:0]                 w_cur_tlp_dw;
    logic [10:0]                 w_cur_left;
    logic                        w_last;
    logic [10:0]                 w_beat_dw;
    logic [10:0]                 w_rem_after;
    logic [10:0]                 w_mps_dw;
    logic [10:0]                 w_len;
    logic [12:0]                 w_bc;
    logic [TLP_STRB_WIDTH-1:0]   w_strb;
    logic [TLP_HDR_WIDTH-1:0]    w_hdr;

    assign w_out_free   = !out_valid_q || tx_cpl_tlp_ready;
    assign desc_ready   = (state_q == ST_IDLE) && !rst;
    assign rd_ready     = (state_q == ST_DATA) && w_out_free;
    assign w_desc_fire  = desc_valid && desc_ready;
    assign w_rd_fire    = rd_valid && rd_ready;
    assign w_is_data    = (state_q == ST_DATA);

    assign w_mps_dw     = (max_payload_size > 3'd5) ? 11'd1024 : (11'd32 << max_payload_size);
    assign w_new_tlp_dw = (rem_dw_q < mps_dw_q) ? rem_dw_q : mps_dw_q;
    assign w_cur_tlp_dw = in_tlp_q ? tlp_dw_q : w_new_tlp_dw;
    assign w_cur_left   = in_tlp_q ? tlp_left_q : w_new_tlp_dw;
    assign w_last       = (w_cur_left <= c_strb_dw);
    assign w_beat_dw    = w_last ? w_cur_left : c_strb_dw;
    assign w_rem_after  = rem_dw_q - w_cur_tlp_dw;

    // rem_dw_q only drops at eop, so it is the byte-count base for every beat
    assign w_len = w_is_data ? w_cur_tlp_dw : 11'd0;
    assign w_bc  = w_is_data ? {rem_dw_q, 2'b00} : 13'd4;
    assign w_hdr = {w_is_data ? 3'b010 : 3'b000, 5'b01010, 1'b0, tc_q, 1'b0, attr_q[2],
                    4'b0000, attr_q[1:0], 2'b00, w_len[9:0],
                    completer_id, status_q, 1'b0, w_bc[11:0],
                    req_id_q, tag_q, 1'b0, lower_addr_q,
                    32'h0000_0000};

    always_comb begin
        w_strb = '0;
        for (int i = 0; i < TLP_STRB_WIDTH; i++) begin
            w_strb[i] = (11'(i) < w_beat_dw);
        end
    end

    always_comb begin
        state_d      = state_q;
        req_id_d     = req_id_q;
        tag_d        = tag_q;
        tc_d         = tc_q;
        attr_d       = attr_q;
        status_d     = status_q;
        lower_addr_d = lower_addr_q;
        rem_dw_d     = rem_dw_q;
        mps_dw_d     = mps_dw_q;
        in_tlp_d     = in_tlp_q;
        tlp_dw_d     = tlp_dw_q;
        tlp_left_d   = tlp_left_q;
        out_valid_d  = out_valid_q;
        out_sop_d    = out_sop_q;
        out_eop_d    = out_eop_q;
        out_strb_d   = out_strb_q;
        out_data_d   = out_data_q;
        out_hdr_d    = out_hdr_q;

        if (out_valid_q && tx_cpl_tlp_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (w_desc_fire) begin
                    req_id_d     = desc_requester_id;
                    tag_d        = desc_tag;
                    tc_d         = desc_tc;
                    attr_d       = desc_attr;
                    status_d     = desc_status;
                    lower_addr_d = desc_lower_addr;
                    rem_dw_d     = (desc_dw_count == 11'd0) ? 11'd1024 : desc_dw_count;
                    mps_dw_d     = w_mps_dw;
                    in_tlp_d     = 1'b0;
                    state_d      = (desc_status != 3'd0) ? ST_NODATA : ST_DATA;
                end
            end
            ST_NODATA: begin
                if (w_out_free) begin
                    out_valid_d = 1'b1;
                    out_sop_d   = 1'b1;
                    out_eop_d   = 1'b1;
                    out_strb_d  = '0;
                    out_data_d  = '0;
                    out_hdr_d   = w_hdr;
                    state_d     = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (w_rd_fire) begin
                    out_valid_d = 1'b1;
                    out_sop_d   = !in_tlp_q;
                    out_eop_d   = w_last;
                    out_strb_d  = w_strb;
                    out_data_d  = rd_data;
                    out_hdr_d   = w_hdr;
                    if (w_last) begin
                        in_tlp_d     = 1'b0;
                        rem_dw_d     = w_rem_after;
                        lower_addr_d = lower_addr_q + {w_cur_tlp_dw[4:0], 2'b00};
                        if (w_rem_after == 11'd0) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        in_tlp_d   = 1'b1;
                        tlp_dw_d   = w_cur_tlp_dw;
                        tlp_left_d = w_cur_left - c_strb_dw;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            req_id_q     <= '0;
            tag_q        <= '0;
            tc_q         <= '0;
            attr_q       <= '0;
            status_q     <= '0;
            lower_addr_q <= '0;
            rem_dw_q     <= '0;
            mps_dw_q     <= '0;
            in_tlp_q     <= 1'b0;
            tlp_dw_q     <= '0;
            tlp_left_q   <= '0;
            out_valid_q  <= 1'b0;
            out_sop_q    <= 1'b0;
            out_eop_q    <= 1'b0;
            out_strb_q   <= '0;
            out_data_q   <= '0;
            out_hdr_q    <= '0;
        end else begin
            state_q      <= state_d;
            req_id_q     <= req_id_d;
            tag_q        <= tag_d;
            tc_q         <= tc_d;
            attr_q       <= attr_d;
            status_q     <= status_d;
            lower_addr_q <= lower_addr_d;
            rem_dw_q     <= rem_dw_d;
            mps_dw_q     <= mps_dw_d;
            in_tlp_q     <= in_tlp_d;
            tlp_dw_q     <= tlp_dw_d;
            tlp_left_q   <= tlp_left_d;
            out_valid_q  <= out_valid_d;
            out_sop_q    <= out_sop_d;
            out_eop_q    <= out_eop_d;
            out_strb_q   <= out_strb_d;
            out_data_q   <= out_data_d;
            out_hdr_q    <= out_hdr_d;
        end
    end

    assign tx_cpl_tlp_valid = out_valid_q;
    assign tx_cpl_tlp_sop   = out_sop_q;
    assign tx_cpl_tlp_eop   = out_eop_q;
    assign tx_cpl_tlp_strb  = out_strb_q;
    assign tx_cpl_tlp_data  = out_data_q;
    assign tx_cpl_tlp_hdr   = out_hdr_q;

`ifdef CPL_STATS_EN
    logic [31:0] stat_cpl_q;
    logic [15:0] stat_ur_q;
    logic [15:0] stat_ca_q;
    logic        w_tx_fire;
    logic        w_nodata_beat;

    assign w_tx_fire     = out_valid_q && tx_cpl_tlp_ready;
    assign w_nodata_beat = (out_hdr_q[127:125] == 3'b000);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_cpl_q <= '0;
            stat_ur_q  <= '0;
            stat_ca_q  <= '0;
        end else if (w_tx_fire) begin
            if (out_eop_q && (stat_cpl_q != '1)) begin
                stat_cpl_q <= stat_cpl_q + 32'd1;
            end
            if (w_nodata_beat && (out_hdr_q[79:77] == 3'd1) && (stat_ur_q != '1)) begin
                stat_ur_q <= stat_ur_q + 16'd1;
            end
            if (w_nodata_beat && (out_hdr_q[79:77] == 3'd4) && (stat_ca_q != '1)) begin
                stat_ca_q <= stat_ca_q + 16'd1;
            end
        end
    end

    assign stat_cpl_count = stat_cpl_q;
    assign stat_ur_count  = stat_ur_q;
    assign stat_ca_count  = stat_ca_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pcie_cpl_tlp_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pcie_cpl_tlp_gen
// Purpose  : Randomized self-checking bench for pcie_cpl_tlp_gen against a
//            TLP-level reference model of the completion split rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcie_cpl_tlp_gen;

    logic         clk;
    logic         rst;
    logic [15:0]  completer_id;
    logic [2:0]   max_payload_size;
    logic         desc_valid;
    logic         desc_ready;
    logic [15:0]  desc_requester_id;
    logic [7:0]   desc_tag;
    logic [2:0]   desc_tc;
    logic [2:0]   desc_attr;
    logic [6:0]   desc_lower_addr;
    logic [10:0]  desc_dw_count;
    logic [2:0]   desc_status;
    logic [255:0] rd_data;
    logic         rd_valid;
    logic         rd_ready;
    logic [255:0] tx_cpl_tlp_data;
    logic [7:0]   tx_cpl_tlp_strb;
    logic [127:0] tx_cpl_tlp_hdr;
    logic         tx_cpl_tlp_valid;
    logic         tx_cpl_tlp_sop;
    logic         tx_cpl_tlp_eop;
    logic         tx_cpl_tlp_ready;
`ifdef CPL_STATS_EN
    logic [31:0]  stat_cpl_count;
    logic [15:0]  stat_ur_count;
    logic [15:0]  stat_ca_count;
`endif

    pcie_cpl_tlp_gen u_dut (
        .clk               (clk),
        .rst               (rst),
        .completer_id      (completer_id),
        .max_payload_size  (max_payload_size),
        .desc_valid        (desc_valid),
        .desc_ready        (desc_ready),
        .desc_requester_id (desc_requester_id),
        .desc_tag          (desc_tag),
        .desc_tc           (desc_tc),
        .desc_attr         (desc_attr),
        .desc_lower_addr   (desc_lower_addr),
        .desc_dw_count     (desc_dw_count),
        .desc_status       (desc_status),
        .rd_data           (rd_data),
        .rd_valid          (rd_valid),
        .rd_ready          (rd_ready),
        .tx_cpl_tlp_data   (tx_cpl_tlp_data),
        .tx_cpl_tlp_strb   (tx_cpl_tlp_strb),
        .tx_cpl_tlp_hdr    (tx_cpl_tlp_hdr),
        .tx_cpl_tlp_valid  (tx_cpl_tlp_valid),
        .tx_cpl_tlp_sop    (tx_cpl_tlp_sop),
        .tx_cpl_tlp_eop    (tx_cpl_tlp_eop),
        .tx_cpl_tlp_ready  (tx_cpl_tlp_ready)
`ifdef CPL_STATS_EN
        ,
        .stat_cpl_count    (stat_cpl_count),
        .stat_ur_count     (stat_ur_count),
        .stat_ca_count     (stat_ca_count)
`endif
    );

    typedef struct {
        logic [127:0] hdr;
        logic [7:0]   strb;
        logic         sop;
        logic         eop;
        logic [255:0] data;
    } beat_t;

    beat_t        exp_q[$];
    logic [255:0] rd_q[$];
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           rmode = 0;
    bit           gap_en = 0;
    bit           decoy = 0;
    bit           rd_fire_s = 0;
    int           rd_fires = 0;
    int           hs_cnt = 0;
    int           hs_mark = 0;
    int           first_hs_cyc = 0;
    int           last_hs_cyc = 0;
    bit           stall = 0;
    logic [255:0] st_data;
    logic [127:0] st_hdr;
    logic [7:0]   st_strb;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // sink ready: 0 = always, 1 = alternating 1010, 2 = random
    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       tx_cpl_tlp_ready = 1'b1;
            1:       tx_cpl_tlp_ready = ~tx_cpl_tlp_ready;
            default: tx_cpl_tlp_ready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) rd_fire_s = rd_valid && rd_ready && !rst;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            rd_q.delete();
            rd_valid = 1'b0;
        end else begin
            if (rd_fire_s) begin
                rd_fires++;
                if (rd_q.size() > 0) void'(rd_q.pop_front());
            end
            if (rd_q.size() > 0) begin
                if (rd_fire_s || !rd_valid) begin
                    if (gap_en && $urandom_range(0, 3) == 0) begin
                        rd_valid = 1'b0;
                    end else begin
                        rd_valid = 1'b1;
                        rd_data  = rd_q[0];
                    end
                end
            end else begin
                rd_valid = decoy;
                rd_data  = {8{32'hDEAD_BEEF}};
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            stall = 0;
        end else begin
            if (stall) begin
                check_val("stall_valid", 256'(tx_cpl_tlp_valid), 256'(1'b1));
                check_val("stall_data", tx_cpl_tlp_data, st_data);
                check_val("stall_hdr", 256'(tx_cpl_tlp_hdr), 256'(st_hdr));
                check_val("stall_strb", 256'(tx_cpl_tlp_strb), 256'(st_strb));
            end
            stall = 0;
            if (tx_cpl_tlp_valid) begin
                if (tx_cpl_tlp_ready) begin
                    if (exp_q.size() == 0) begin
                        check_val("extra_beat", 256'(1'b1), 256'(1'b0));
                    end else begin
                        beat_t e;
                        logic [255:0] m;
                        e = exp_q.pop_front();
                        m = '0;
                        for (int i = 0; i < 8; i++) if (e.strb[i]) m[i*32 +: 32] = '1;
                        check_val("sop", 256'(tx_cpl_tlp_sop), 256'(e.sop));
                        check_val("eop", 256'(tx_cpl_tlp_eop), 256'(e.eop));
                        check_val("strb", 256'(tx_cpl_tlp_strb), 256'(e.strb));
                        if (e.sop) check_val("hdr", 256'(tx_cpl_tlp_hdr), 256'(e.hdr));
                        if (e.strb != 8'h00) check_val("data", tx_cpl_tlp_data & m, e.data & m);
                    end
                    if (hs_cnt == hs_mark) first_hs_cyc = cyc;
                    last_hs_cyc = cyc;
                    hs_cnt++;
                end else begin
                    stall   = 1;
                    st_data = tx_cpl_tlp_data;
                    st_hdr  = tx_cpl_tlp_hdr;
                    st_strb = tx_cpl_tlp_strb;
                end
            end
        end
    end

    function automatic logic [127:0] mk_hdr(input int fmt, input int len, input int bc, input int st,
                                            input int la, input logic [15:0] rid, input logic [7:0] tg,
                                            input logic [2:0] tc, input logic [2:0] attr);
        logic [31:0] d0, d1, d2;
        d0 = (32'(fmt) << 29) | (32'd10 << 24) | (32'(tc) << 20) | (32'(attr[2]) << 18)
           | (32'(attr[1:0]) << 12) | 32'(len % 1024);
        d1 = {completer_id, 16'h0} | (32'(st) << 13) | 32'(bc % 4096);
        d2 = {rid, 16'h0} | (32'(tg) << 8) | 32'(la % 128);
        return {d0, d1, d2, 32'h0};
    endfunction

    // Expected completion stream, one TLP at a time, from the split rules
    task automatic model(input logic [2:0] st, input logic [10:0] dwc, input logic [6:0] la0,
                         input logic [2:0] mps, input logic [15:0] rid, input logic [7:0] tg,
                         input logic [2:0] tc, input logic [2:0] attr);
        int rem, mps_dw, la, t, nb;
        beat_t b;
        rem    = (dwc == 0) ? 1024 : int'(dwc);
        mps_dw = 32 * (1 << ((mps > 5) ? 5 : int'(mps)));
        la     = int'(la0);
        if (st != 0) begin
            b.hdr = mk_hdr(0, 0, 4, int'(st), la, rid, tg, tc, attr);
            b.strb = 8'h00; b.sop = 1; b.eop = 1; b.data = '0;
            exp_q.push_back(b);
            return;
        end
        while (rem > 0) begin
            t  = (rem < mps_dw) ? rem : mps_dw;
            nb = (t + 7) / 8;
            for (int k = 0; k < nb; k++) begin
                logic [255:0] d;
                for (int w = 0; w < 8; w++) d[w*32 +: 32] = $urandom;
                b.hdr  = mk_hdr(2, t, rem * 4, 0, la, rid, tg, tc, attr);
                b.sop  = (k == 0);
                b.eop  = (k == nb - 1);
                b.strb = (k == nb - 1 && (t % 8) != 0) ? 8'((1 << (t % 8)) - 1) : 8'hFF;
                b.data = d;
                exp_q.push_back(b);
                rd_q.push_back(d);
            end
            rem = rem - t;
            la  = (la + t * 4) % 128;
        end
    endtask

    task automatic present_desc(input logic [2:0] st, input logic [10:0] dwc, input logic [6:0] la,
                                input logic [2:0] mps);
        bit ok;
        desc_requester_id = 16'($urandom);
        desc_tag          = 8'($urandom);
        desc_tc           = 3'($urandom);
        desc_attr         = 3'($urandom);
        desc_status       = st;
        desc_dw_count     = dwc;
        desc_lower_addr   = la;
        max_payload_size  = mps;
        hs_mark           = hs_cnt;
        model(st, dwc, la, mps, desc_requester_id, desc_tag, desc_tc, desc_attr);
        desc_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            ok = desc_ready;
        end
        if (!ok) check_val("desc_timeout", 256'(1'b1), 256'(1'b0));
        @(posedge clk);
        #1;
        desc_valid       = 1'b0;
        max_payload_size = 3'($urandom);
    endtask

    task automatic do_req(input logic [2:0] st, input logic [10:0] dwc, input logic [6:0] la,
                          input logic [2:0] mps);
        present_desc(st, dwc, la, mps);
        for (int i = 0; i < 5000 && exp_q.size() != 0; i++) @(posedge clk);
        check_val("all_beats_out", 256'(exp_q.size()), 256'(0));
        check_val("rd_all_used", 256'(rd_q.size()), 256'(0));
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int f0;
        rst = 1'b1;
        completer_id = 16'hA5C3;
        max_payload_size = 3'd0;
        desc_valid = 1'b0;
        desc_requester_id = '0; desc_tag = '0; desc_tc = '0; desc_attr = '0;
        desc_lower_addr = '0; desc_dw_count = '0; desc_status = '0;
        rd_valid = 1'b0; rd_data = '0;
        tx_cpl_tlp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check_val("rst_valid", 256'(tx_cpl_tlp_valid), 256'(1'b0));
        check_val("rst_desc_ready", 256'(desc_ready), 256'(1'b0));
        check_val("rst_rd_ready", 256'(rd_ready), 256'(1'b0));
        check_val("rst_hdr", 256'(tx_cpl_tlp_hdr), 256'(0));
        rst = 1'b0;
        @(negedge clk);
        check_val("idle_desc_ready", 256'(desc_ready), 256'(1'b1));
        @(posedge clk); #1;

        rmode = 0; gap_en = 0;
        do_req(3'd0, 11'd8, 7'd0, 3'd0);
        do_req(3'd0, 11'd40, 7'd0, 3'd0);
        do_req(3'd0, 11'd0, 7'd12, 3'd5);
        check_val("tput_1024", 256'(last_hs_cyc - first_hs_cyc), 256'(127));

        decoy = 1; f0 = rd_fires;
        do_req(3'd1, 11'd16, 7'd8, 3'd0);
        do_req(3'd4, 11'd3, 7'd4, 3'd1);
        check_val("nodata_rd_fires", 256'(rd_fires - f0), 256'(0));
        decoy = 0;
        repeat (2) @(posedge clk); #1;

        rmode = 1;
        do_req(3'd0, 11'd11, 7'd20, 3'd0);
        rmode = 0;

        // reset while beat 2 of a 4-beat TLP is on the bus
        present_desc(3'd0, 11'd32, 7'd0, 3'd0);
        for (int i = 0; i < 200 && hs_cnt < hs_mark + 1; i++) @(negedge clk);
        @(negedge clk);
        check_val("beat2_shown", 256'(tx_cpl_tlp_valid), 256'(1'b1));
        #2 rst = 1'b1;
        #1;
        check_val("rst_mid_valid", 256'(tx_cpl_tlp_valid), 256'(1'b0));
        check_val("rst_mid_eop", 256'(tx_cpl_tlp_eop), 256'(1'b0));
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        do_req(3'd0, 11'd11, 7'd4, 3'd2);

        rmode = 2;
        for (int n = 0; n < 30; n++) begin
            int r;
            logic [2:0] st;
            logic [10:0] dwc;
            r  = $urandom_range(0, 5);
            st = (r == 4) ? 3'd1 : (r == 5) ? 3'd4 : 3'd0;
            r  = $urandom_range(0, 9);
            dwc = (r == 0) ? 11'd0 : (r < 4) ? 11'($urandom_range(1, 16)) : 11'($urandom_range(1, 300));
            gap_en = 1'($urandom_range(0, 1));
            do_req(st, dwc, {5'($urandom), 2'b00}, 3'($urandom_range(0, 7)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pcie_cpl_tlp_gen.md
Name: pcie_cpl_tlp_gen

Overview:
Completion TLP generator feeding the tx_cpl_tlp_* stream of the PCIe-to-AXI bridge. It consumes one completion descriptor per non-posted request plus dword-packed read-data beats returned from the AXI side. It emits header+data completion TLPs, split at max_payload_size. Single-segment stream (TLP_SEG_COUNT = 1).

Parameters:
TLP_DATA_WIDTH, 256, data bus width in bits; multiple of 32, at most 1024
TLP_STRB_WIDTH, TLP_DATA_WIDTH/32, one strobe bit per dword
TLP_HDR_WIDTH, 128, header bus width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
completer_id  in  16  bus/dev/fn inserted in every header
max_payload_size  in  3  MPS code; payload bytes = 128<<code; codes >5 clamp to 5 (4096)
desc_valid  in  1  descriptor valid
desc_ready  out  1  descriptor accepted when valid&ready
desc_requester_id  in  16  requester ID
desc_tag  in  8  request tag
desc_tc  in  3  traffic class
desc_attr  in  3  attributes
desc_lower_addr  in  7  start address [6:0], dword aligned ([1:0]=0)
desc_dw_count  in  11  dwords requested; 1..1024, 0 means 1024
desc_status  in  3  0=SC, 1=UR, 4=CA
rd_data  in  TLP_DATA_WIDTH  read data, dword 0 in bits [31:0]
rd_valid  in  1  read beat valid
rd_ready  out  1  read beat accepted when valid&ready
tx_cpl_tlp_data  out  TLP_DATA_WIDTH  completion payload
tx_cpl_tlp_strb  out  TLP_STRB_WIDTH  valid dwords in beat
tx_cpl_tlp_hdr  out  TLP_HDR_WIDTH  header, valid on sop beat
tx_cpl_tlp_valid  out  1  beat valid
tx_cpl_tlp_sop  out  1  first beat of TLP
tx_cpl_tlp_eop  out  1  last beat of TLP
tx_cpl_tlp_ready  in  1  sink ready

Behaviour:
- Reset, asynchronous: all tx_cpl_tlp_* outputs 0, desc_ready 0, rd_ready 0, FSM in IDLE, all counters 0.
- FSM states:
  - IDLE: desc_ready=1. On accept, latch the descriptor and remaining_dw (0 maps to 1024). desc_status!=0 -> NODATA; else -> DATA.
  - NODATA: output one beat: Cpl header, sop=eop=1, strb=0, byte count=4. After handshake -> IDLE.
  - DATA: rd_ready=1 when the output register is empty or being drained. Each accepted beat is registered to the output 1 cycle later.
- Completion split:
  - A new TLP starts when remaining_dw>0 and the previous TLP ended.
  - tlp_dw = min(remaining_dw, MPS/4).
  - Beats per TLP = ceil(tlp_dw / TLP_STRB_WIDTH).
  - sop on the first beat, eop on the last. strb is all ones except the last beat, where it is the low (tlp_dw mod TLP_STRB_WIDTH) bits, or all ones if that is 0.
  - At eop, remaining_dw -= tlp_dw and lower_addr += tlp_dw*4 (7-bit wrap). When remaining_dw reaches 0 -> IDLE.
- Header packing (hdr[31:0]=0):
  - DW0 in [127:96]: fmt 3'b010 (CplD) or 3'b000 (Cpl); type 5'b01010; tc [22:20]; attr[2] at [18]; attr[1:0] at [13:12]; length [9:0] = tlp_dw (1024 encodes as 0).
  - DW1 in [95:64]: completer_id [31:16]; status [15:13]; BCM=0; byte count [11:0] = remaining_dw*4 before this TLP (4096 encodes as 0).
  - DW2 in [63:32]: requester_id [31:16]; tag [15:8]; lower_addr [6:0].
- Handshake:
  - Output holds all fields stable while valid&!ready.
  - No bubble is inserted when ready is held high: throughput is 1 beat/cycle.
  - rd beats beyond the descriptor's dword count are not accepted (rd_ready=0 in IDLE/NODATA).
- max_payload_size is sampled at descriptor accept. Changes mid-request have no effect.
- Reset mid-TLP: the output is dropped immediately and no eop is generated.

Optional Feature:
CPL_STATS_EN. When defined, adds outputs stat_cpl_count[31:0] (completion TLPs sent, counted at eop handshake), stat_ur_count[15:0] and stat_ca_count[15:0] (no-data completions with UR/CA). Counters saturate and reset to 0. When undefined, these ports and the counters are absent.

Test Plan:
- SC, dw_count=8, MPS=0, ready=1 -> one TLP, 1 beat, sop=eop=1, strb=8'hFF, length=8, byte count=32, fmt=010.
- SC, dw_count=40, MPS=0 (32 DW), lower_addr=0 -> TLP1: 4 beats, length 32, byte count 160, lower_addr 0. TLP2: 1 beat, length 8, byte count 32, lower_addr 0 (128 wraps).
- SC, dw_count=0 (1024 DW), MPS=5 -> one TLP, 128 beats, length field 0, byte count field 0.
- desc_status=1 (UR) -> single Cpl beat, fmt 000, strb 0, byte count 4, no rd beats consumed.
- SC, dw_count=11, tx ready toggling 1010 -> data/strb stable during stalls, last beat strb=8'h07, no beat lost or duplicated.
- Assert rst during beat 2 of a 4-beat TLP -> valid=0 asynchronously. Next descriptor completes normally with sop on its first beat.
